// File: rtl/seven_segment_decoder.sv
// ---------------------------------------------------------------------------
// seven_segment_decoder
//
// Receive-side counterpart of a binary-to-7-segment encoder. The eight
// segment lines are synchronized, normalized so that a lit segment reads 1,
// debounced until STABLE_CYCLES consecutive identical samples are seen, and
// then mapped back to a 4-bit hex value. Blank and illegal patterns are
// flagged. Used as a loopback checker and as a front-panel readback monitor.
//
// Parameters:
//   STABLE_CYCLES   consecutive identical samples needed to accept (1-255)
//   SEG_ACTIVE_LOW  1 when a lit segment is driven low on the pins
//
// Ports:
//   i_Clk            system clock
//   i_Rst            asynchronous active-high reset
//   i_EN             decoder enable
//   i_Segment_A..G   segment lines
//   i_Segment_DP     decimal point line
//   o_Binary_Num     last accepted legal hex value
//   o_DP             DP bit of the last accepted pattern
//   o_Valid          one-cycle pulse when a new pattern is accepted
//   o_Blank          last accepted pattern has A-G all unlit
//   o_Invalid        last accepted pattern is not in the decode table
//   o_Err_Count      (SEG_DEC_ERR_COUNT_EN only) saturating count of
//                    accepted illegal patterns
//
// Optional feature macro: SEG_DEC_ERR_COUNT_EN
// ---------------------------------------------------------------------------
module seven_segment_decoder #(
  parameter int STABLE_CYCLES  = 4,
  parameter int SEG_ACTIVE_LOW = 0
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_EN,
  input  logic       i_Segment_A,
  input  logic       i_Segment_B,
  input  logic       i_Segment_C,
  input  logic       i_Segment_D,
  input  logic       i_Segment_E,
  input  logic       i_Segment_F,
  input  logic       i_Segment_G,
  input  logic       i_Segment_DP,
  output logic [3:0] o_Binary_Num,
  output logic       o_DP,
  output logic       o_Valid,
  output logic       o_Blank,
  output logic       o_Invalid
`ifdef SEG_DEC_ERR_COUNT_EN
  ,
  output logic [7:0] o_Err_Count
`endif
);

  // Pin level of an unlit segment; XOR with it normalizes to lit = 1.
  localparam logic [7:0] UNLIT      = (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [7:0] STABLE_MAX = 8'(STABLE_CYCLES);

  typedef enum logic [1:0] {
    ST_DISABLED,
    ST_SETTLE,
    ST_LOCKED
  } state_t;

  logic [7:0] pins;
  logic [7:0] sync_1;
  logic [7:0] sync_2;
  logic [7:0] sample;
  logic [7:0] prev_sample;
  logic       changed;
  logic       reach_stable;
  logic [7:0] count;
  logic [7:0] last_word;
  state_t     state;
  logic [3:0] dec_num;
  logic       dec_legal;
  logic       dec_blank;

  assign pins = {i_Segment_A, i_Segment_B, i_Segment_C, i_Segment_D,
                 i_Segment_E, i_Segment_F, i_Segment_G, i_Segment_DP};

  // Two-flop synchronizer; flops reset to the unlit pin level.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      sync_1 <= UNLIT;
      sync_2 <= UNLIT;
    end else begin
      sync_1 <= pins;
      sync_2 <= sync_1;
    end
  end

  // The sample arriving at this edge (sync_1) is compared with the one
  // already held (sync_2), so a decision is made on the same edge that the
  // sample becomes the synchronized word.
  assign sample       = sync_1 ^ UNLIT;
  assign prev_sample  = sync_2 ^ UNLIT;
  assign changed      = (sample != prev_sample);
  assign reach_stable = (({1'b0, count} + 9'd1) >= {1'b0, STABLE_MAX});

  // Decode of A-G (A is the MSB); 73 is accepted as an alternate 9.
  always_comb begin
    dec_num   = 4'h0;
    dec_legal = 1'b1;
    dec_blank = (sample[7:1] == 7'h00);
    case (sample[7:1])
      7'h7E:   dec_num = 4'h0;
      7'h30:   dec_num = 4'h1;
      7'h6D:   dec_num = 4'h2;
      7'h79:   dec_num = 4'h3;
      7'h33:   dec_num = 4'h4;
      7'h5B:   dec_num = 4'h5;
      7'h5F:   dec_num = 4'h6;
      7'h70:   dec_num = 4'h7;
      7'h7F:   dec_num = 4'h8;
      7'h7B:   dec_num = 4'h9;
      7'h73:   dec_num = 4'h9;
      7'h77:   dec_num = 4'hA;
      7'h1F:   dec_num = 4'hB;
      7'h4E:   dec_num = 4'hC;
      7'h3D:   dec_num = 4'hD;
      7'h4F:   dec_num = 4'hE;
      7'h47:   dec_num = 4'hF;
      default: dec_legal = 1'b0;
    endcase
  end

  // Stability FSM with registered outputs. Leaving DISABLED already counts
  // the current sample when it is unchanged, so a pattern that was steady
  // while disabled is accepted STABLE_CYCLES edges after i_EN rises.
  // An accepted word equal to the previous one (a glitch that came back)
  // changes nothing and does not pulse.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state        <= ST_DISABLED;
      count        <= 8'd0;
      last_word    <= 8'h00;
      o_Binary_Num <= 4'h0;
      o_DP         <= 1'b0;
      o_Valid      <= 1'b0;
      o_Blank      <= 1'b1;
      o_Invalid    <= 1'b0;
`ifdef SEG_DEC_ERR_COUNT_EN
      o_Err_Count  <= 8'd0;
`endif
    end else begin
      o_Valid <= 1'b0;
      if (!i_EN) begin
        state <= ST_DISABLED;
        count <= 8'd0;
      end else begin
        case (state)
          ST_DISABLED: begin
            state <= ST_SETTLE;
            count <= changed ? 8'd0 : 8'd1;
          end
          ST_SETTLE: begin
            if (changed) begin
              count <= 8'd0;
            end else if (reach_stable) begin
              state <= ST_LOCKED;
              count <= STABLE_MAX;
              if (sample != last_word) begin
                last_word <= sample;
                o_Valid   <= 1'b1;
                o_DP      <= sample[0];
                if (dec_blank) begin
                  o_Blank   <= 1'b1;
                  o_Invalid <= 1'b0;
                end else if (dec_legal) begin
                  o_Binary_Num <= dec_num;
                  o_Blank      <= 1'b0;
                  o_Invalid    <= 1'b0;
                end else begin
                  o_Blank   <= 1'b0;
                  o_Invalid <= 1'b1;
`ifdef SEG_DEC_ERR_COUNT_EN
                  if (o_Err_Count != 8'hFF) begin
                    o_Err_Count <= o_Err_Count + 8'd1;
                  end
`endif
                end
              end
            end else begin
              count <= count + 8'd1;
            end
          end
          ST_LOCKED: begin
            if (changed) begin
              state <= ST_SETTLE;
              count <= 8'd0;
            end
          end
          default: begin
            state <= ST_DISABLED;
            count <= 8'd0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_seven_segment_decoder.sv
// ---------------------------------------------------------------------------
// tb_seven_segment_decoder
//
// Directed self-checking bench for seven_segment_decoder at the default
// parameters. Pins change 1 ns after a rising edge; outputs are read 1 ns
// after a rising edge, and o_Valid pulses are logged on falling edges
// together with the index of the rising edge that produced them.
// ---------------------------------------------------------------------------
module tb_seven_segment_decoder;

  logic       i_Clk;
  logic       i_Rst;
  logic       i_EN;
  logic       seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp;
  logic [3:0] o_Binary_Num;
  logic       o_DP;
  logic       o_Valid;
  logic       o_Blank;
  logic       o_Invalid;
`ifdef SEG_DEC_ERR_COUNT_EN
  logic [7:0] o_Err_Count;
`endif

  int vec_cnt;
  int miss_cnt;
  int edge_cnt;
  int pulse_cnt;
  int pulse_edge;
  int drive_edge;
  int pulses_before;

  logic [6:0] seg_tab [17];
  int         val_tab [17];

  seven_segment_decoder dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_EN         (i_EN),
    .i_Segment_A  (seg_a),
    .i_Segment_B  (seg_b),
    .i_Segment_C  (seg_c),
    .i_Segment_D  (seg_d),
    .i_Segment_E  (seg_e),
    .i_Segment_F  (seg_f),
    .i_Segment_G  (seg_g),
    .i_Segment_DP (seg_dp),
    .o_Binary_Num (o_Binary_Num),
    .o_DP         (o_DP),
    .o_Valid      (o_Valid),
    .o_Blank      (o_Blank),
    .o_Invalid    (o_Invalid)
`ifdef SEG_DEC_ERR_COUNT_EN
    ,
    .o_Err_Count  (o_Err_Count)
`endif
  );

  // 100 MHz clock
  initial begin
    i_Clk = 1'b0;
    forever #5 i_Clk = ~i_Clk;
  end

  // Rising-edge index, used to measure pulse latency
  always @(posedge i_Clk) edge_cnt++;

  // Log every o_Valid pulse away from the active edge
  always @(negedge i_Clk) begin
    if (o_Valid) begin
      pulse_cnt++;
      pulse_edge = edge_cnt;
    end
  end

  // Single comparison point: counts the vector and reports a miscompare
  task automatic checkOutput(input string tag, input int observed, input int expected);
    vec_cnt++;
    if (observed !== expected) begin
      miss_cnt++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  // Drive a pattern 1 ns after the next rising edge and remember that edge
  task automatic applyStimulus(input logic [6:0] seg, input logic dp);
    @(posedge i_Clk);
    #1;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g} = seg;
    seg_dp     = dp;
    drive_edge = edge_cnt;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(posedge i_Clk);
    #1;
  endtask

  initial begin
    vec_cnt   = 0;
    miss_cnt  = 0;
    edge_cnt  = 0;
    pulse_cnt = 0;
    pulse_edge = -1;
    drive_edge = 0;
    seg_tab = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70, 7'h7F,
                7'h7B, 7'h73, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
    val_tab = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 9, 10, 11, 12, 13, 14, 15};

    i_Rst = 1'b1;
    i_EN  = 1'b0;
    {seg_a, seg_b, seg_c, seg_d, seg_e, seg_f, seg_g, seg_dp} = 8'h00;

    // Reset state
    #12;
    checkOutput("rst_num",     o_Binary_Num, 0);
    checkOutput("rst_dp",      o_DP,         0);
    checkOutput("rst_valid",   o_Valid,      0);
    checkOutput("rst_blank",   o_Blank,      1);
    checkOutput("rst_invalid", o_Invalid,    0);
`ifdef SEG_DEC_ERR_COUNT_EN
    checkOutput("rst_errcnt",  o_Err_Count,  0);
`endif
    @(negedge i_Clk);
    i_Rst = 1'b0;
    i_EN  = 1'b1;
    waitCycles(10);
    // Blank pins equal the reset word, so locking on them must be silent
    checkOutput("idle_no_pulse", pulse_cnt, 0);

    // 1: first legal pattern, latency of 6 edges
    $display("[TB] test 1: first pattern 7E");
    pulses_before = pulse_cnt;
    applyStimulus(7'h7E, 1'b0);
    waitCycles(10);
    checkOutput("t1_pulses",  pulse_cnt - pulses_before, 1);
    checkOutput("t1_latency", pulse_edge - drive_edge, 6);
    checkOutput("t1_num",     o_Binary_Num, 0);
    checkOutput("t1_blank",   o_Blank, 0);
    checkOutput("t1_invalid", o_Invalid, 0);

    // Blank pattern: flagged, value held
    pulses_before = pulse_cnt;
    applyStimulus(7'h00, 1'b0);
    waitCycles(10);
    checkOutput("blank_pulses",  pulse_cnt - pulses_before, 1);
    checkOutput("blank_blank",   o_Blank, 1);
    checkOutput("blank_invalid", o_Invalid, 0);
    checkOutput("blank_num",     o_Binary_Num, 0);

    // 2: sweep the whole decode table
    $display("[TB] test 2: table sweep");
    for (int i = 0; i < 17; i++) begin
      pulses_before = pulse_cnt;
      applyStimulus(seg_tab[i], 1'b0);
      waitCycles(19);
      checkOutput($sformatf("t2_pulses_%0d", i), pulse_cnt - pulses_before, 1);
      checkOutput($sformatf("t2_num_%0d", i), o_Binary_Num, val_tab[i]);
    end

    // 3: glitch that returns to the locked pattern
    $display("[TB] test 3: glitch rejection");
    applyStimulus(7'h30, 1'b0);
    waitCycles(10);
    checkOutput("t3_lock_num", o_Binary_Num, 1);
    pulses_before = pulse_cnt;
    applyStimulus(7'h7F, 1'b0);
    waitCycles(1);
    applyStimulus(7'h30, 1'b0);
    waitCycles(15);
    checkOutput("t3_no_pulse", pulse_cnt - pulses_before, 0);
    checkOutput("t3_num",      o_Binary_Num, 1);

    // 4: illegal pattern holds the value
    $display("[TB] test 4: illegal pattern");
    applyStimulus(7'h33, 1'b0);
    waitCycles(10);
    checkOutput("t4_lock_num", o_Binary_Num, 4);
    pulses_before = pulse_cnt;
    applyStimulus(7'h2A, 1'b0);
    waitCycles(10);
    checkOutput("t4_pulses",  pulse_cnt - pulses_before, 1);
    checkOutput("t4_invalid", o_Invalid, 1);
    checkOutput("t4_blank",   o_Blank, 0);
    checkOutput("t4_num",     o_Binary_Num, 4);
`ifdef SEG_DEC_ERR_COUNT_EN
    checkOutput("t4_errcnt_1", o_Err_Count, 1);
    for (int i = 0; i < 300; i++) begin
      applyStimulus(7'h30, 1'b0);
      waitCycles(8);
      applyStimulus(7'h2A, 1'b0);
      waitCycles(8);
    end
    checkOutput("t4_errcnt_sat", o_Err_Count, 255);
`endif
    applyStimulus(7'h30, 1'b0);
    waitCycles(10);
    checkOutput("t4_recover_invalid", o_Invalid, 0);
    checkOutput("t4_recover_num",     o_Binary_Num, 1);

    // 5: DP-only change, then enable drop and re-enable
    $display("[TB] test 5: DP change and enable");
    applyStimulus(7'h6D, 1'b0);
    waitCycles(10);
    pulses_before = pulse_cnt;
    applyStimulus(7'h6D, 1'b1);
    waitCycles(10);
    checkOutput("t5_dp_pulses", pulse_cnt - pulses_before, 1);
    checkOutput("t5_dp",        o_DP, 1);
    checkOutput("t5_dp_num",    o_Binary_Num, 2);
    pulses_before = pulse_cnt;
    applyStimulus(7'h79, 1'b0);
    waitCycles(1);
    @(posedge i_Clk);
    #1;
    i_EN = 1'b0;
    waitCycles(10);
    checkOutput("t5_dis_no_pulse", pulse_cnt - pulses_before, 0);
    checkOutput("t5_dis_num",      o_Binary_Num, 2);
    pulses_before = pulse_cnt;
    @(posedge i_Clk);
    #1;
    i_EN       = 1'b1;
    drive_edge = edge_cnt;
    waitCycles(10);
    checkOutput("t5_en_pulses",  pulse_cnt - pulses_before, 1);
    checkOutput("t5_en_latency", pulse_edge - drive_edge, 4);
    checkOutput("t5_en_num",     o_Binary_Num, 3);
    checkOutput("t5_en_dp",      o_DP, 0);

    // 6: asynchronous reset mid-settle
    $display("[TB] test 6: reset mid-settle");
    applyStimulus(7'h47, 1'b0);
    waitCycles(3);
    #2;
    i_Rst = 1'b1;
    #1;
    checkOutput("t6_rst_num",     o_Binary_Num, 0);
    checkOutput("t6_rst_blank",   o_Blank, 1);
    checkOutput("t6_rst_invalid", o_Invalid, 0);
    checkOutput("t6_rst_dp",      o_DP, 0);
    pulses_before = pulse_cnt;
    @(posedge i_Clk);
    #1;
    i_Rst      = 1'b0;
    drive_edge = edge_cnt;
    waitCycles(10);
    checkOutput("t6_pulses",  pulse_cnt - pulses_before, 1);
    checkOutput("t6_latency", pulse_edge - drive_edge, 6);
    checkOutput("t6_num",     o_Binary_Num, 15);
    checkOutput("t6_blank",   o_Blank, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
